// File: rtl/slow_clk_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : slow_clk_monitor_if
// Description : Bundle carrying the slow toggling clock into the monitor and
//               the tick / measurement / status results back out of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface slow_clk_monitor_if #(
    parameter int CNT_W = 26
);
    logic             clk_d;
    logic             tick_rise;
    logic             tick_fall;
    logic             tick_any;
    logic [CNT_W-1:0] half_period;
    logic             locked;
    logic             lost;

    // Source side: supplies the slow clock and consumes the results
    modport master (
        output clk_d,
        input  tick_rise,
        input  tick_fall,
        input  tick_any,
        input  half_period,
        input  locked,
        input  lost
    );

    // Monitor side: samples the slow clock and produces the results
    modport slave (
        input  clk_d,
        output tick_rise,
        output tick_fall,
        output tick_any,
        output half_period,
        output locked,
        output lost
    );
endinterface
`default_nettype wire

// File: rtl/slow_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : slow_clk_monitor
// Description : Synchronises a slow toggling clock into the clk domain,
//               emits single-cycle rise/fall/any tick pulses, measures the
//               half-period in clk cycles and reports locked / lost status.
// Revision    : 1.0 - initial release
// ============================================================================
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,        // synchroniser depth, >= 2
    parameter int CNT_W       = 26,       // half-period counter width
    parameter int TIMEOUT     = 8333332   // cycles without an edge before lost
) (
    input  wire               clk,
    input  wire               rst_n,
    slow_clk_monitor_if.slave bus
);

    // Arming counter only has to reach SYNC_STAGES
    localparam int               c_arm_w      = $clog2(SYNC_STAGES + 2);
    localparam logic [c_arm_w-1:0] c_arm_last = c_arm_w'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ACQ1   = 2'd0,
        ST_ACQ2   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [c_arm_w-1:0]     r_arm_cnt;
    logic                   r_armed;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_half_period;
    logic                   r_tick_rise;
    logic                   r_tick_fall;
    logic                   r_tick_any;
    logic                   r_locked;
    logic                   r_lost;
    state_t                 r_state;
    state_t                 w_state_next;

    logic w_sync_out;
    logic w_edge;
    logic w_rise;
    logic w_fall;
    logic w_timeout;
    logic w_measure;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // Edges are only believed once the chain has flushed its reset contents
    assign w_edge     = r_armed & (w_sync_out ^ r_prev);
    assign w_rise     = w_edge & w_sync_out;
    assign w_fall     = w_edge & ~w_sync_out;
    // An edge in the boundary cycle takes priority over the timeout
    assign w_timeout  = (r_cnt == c_timeout_m1) & ~w_edge;
    assign w_measure  = w_edge & ((r_state == ST_ACQ2) || (r_state == ST_LOCKED));

    // Metastability chain plus one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.clk_d};
            r_prev <= w_sync_out;
        end
    end

    // Arm edge detection SYNC_STAGES+1 cycles after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (r_arm_cnt == c_arm_last) begin
                r_armed <= 1'b1;
            end else begin
                r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
            end
        end
    end

    // Cycles since the last edge, saturating so the +1 below never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (r_cnt < c_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Latch the half-period once acquisition has seen a reference edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_period <= '0;
        end else if (w_measure) begin
            r_half_period <= r_cnt + CNT_W'(1);
        end
    end

    // Single-cycle tick pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            r_tick_any  <= 1'b0;
        end else begin
            r_tick_rise <= w_rise;
            r_tick_fall <= w_fall;
            r_tick_any  <= w_edge;
        end
    end

    // State register with registered status flags decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ACQ1;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == ST_LOCKED);
            r_lost   <= (w_state_next == ST_LOST);
        end
    end

    // Acquisition / lock / loss transitions; ACQ1 never times out
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACQ1: begin
                if (w_edge) w_state_next = ST_ACQ2;
            end
            ST_ACQ2: begin
                if (w_edge)         w_state_next = ST_LOCKED;
                else if (w_timeout) w_state_next = ST_LOST;
            end
            ST_LOCKED: begin
                if (w_timeout) w_state_next = ST_LOST;
            end
            ST_LOST: begin
                if (w_edge) w_state_next = ST_ACQ2;
            end
            default: w_state_next = ST_ACQ1;
        endcase
    end

    assign bus.tick_rise   = r_tick_rise;
    assign bus.tick_fall   = r_tick_fall;
    assign bus.tick_any    = r_tick_any;
    assign bus.half_period = r_half_period;
    assign bus.locked      = r_locked;
    assign bus.lost        = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_clk_monitor
// Description : Self-checking bench for slow_clk_monitor: cycle table for
//               arming, tick latency and first lock, then directed sequences
//               for timeout/recovery, timeout boundary and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_clk_monitor;

    localparam int CNT_W       = 26;
    localparam int TIMEOUT     = 30;
    localparam int SYNC_STAGES = 2;
    localparam int N_VEC       = 20;

    logic clk;
    logic rst_n;

    slow_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

    slow_clk_monitor #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             d;
        logic             rise;
        logic             fall;
        logic             locked;
        logic             lost;
        logic [CNT_W-1:0] hp;
    } vec_t;

    vec_t vecs [N_VEC];

    int   n_pass     = 0;
    int   n_total    = 0;
    int   tog_period = 0;
    int   tog_cnt    = 0;
    logic saw_tick   = 1'b0;
    logic saw_lost   = 1'b0;

    function automatic vec_t mk(input logic d, input logic r, input logic f,
                                input logic lk, input logic ls, input int hp);
        vec_t v;
        v.d = d; v.rise = r; v.fall = f; v.locked = lk; v.lost = ls;
        v.hp = CNT_W'(hp);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clk cycle: sample just after the edge, then advance the toggler
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.tick_any) saw_tick = 1'b1;
        if (bus.lost)     saw_lost = 1'b1;
        if (tog_period != 0) begin
            tog_cnt++;
            if (tog_cnt >= tog_period) begin
                bus.clk_d = ~bus.clk_d;
                tog_cnt   = 0;
            end
        end
    endtask

    task automatic wait_tick(input string name, input int budget, output int cycles);
        logic got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            cyc();
            cycles++;
            got = bus.tick_any;
        end
        check({name, "_seen"}, 64'(got), 64'd1);
    endtask

    task automatic do_reset(input logic d);
        tog_period = 0;
        bus.clk_d  = d;
        rst_n      = 1'b0;
        repeat (3) cyc();
        rst_n   = 1'b1;
        tog_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gap;
        int first_lost;
        int first_unlock;

        // Cycle table, row i is checked after the (i+1)th edge after release
        for (int i = 0; i < N_VEC; i++) vecs[i] = mk(1'b0, 0, 0, 0, 0, 0);
        for (int i = 3; i <= 6; i++)   vecs[i].d = 1'b1;
        for (int i = 11; i <= 16; i++) vecs[i].d = 1'b1;
        vecs[5].rise = 1'b1;
        for (int i = 9; i < N_VEC; i++) begin
            vecs[i].locked = 1'b1;
            vecs[i].hp     = CNT_W'(4);
        end
        vecs[9].fall  = 1'b1;
        vecs[13].rise = 1'b1;
        vecs[19].fall = 1'b1;
        vecs[19].hp   = CNT_W'(6);

        rst_n     = 1'b1;
        bus.clk_d = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (3) cyc();
        check("reset_state",
              64'({bus.tick_rise, bus.tick_fall, bus.tick_any, bus.locked, bus.lost, bus.half_period}),
              64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            bus.clk_d = vecs[i].d;
            cyc();
            check($sformatf("vec%0d", i),
                  64'({bus.tick_rise, bus.tick_fall, bus.tick_any, bus.locked, bus.lost, bus.half_period}),
                  64'({vecs[i].rise, vecs[i].fall, vecs[i].rise | vecs[i].fall,
                       vecs[i].locked, vecs[i].lost, vecs[i].hp}));
        end

        // Nominal lock: toggle every 10 cycles from reset
        do_reset(1'b0);
        tog_period = 10;
        wait_tick("nom_t1", 40, gap);
        check("nom_t1_rise", 64'(bus.tick_rise), 64'd1);
        check("nom_t1_locked", 64'(bus.locked), 64'd0);
        for (int i = 2; i <= 6; i++) begin
            wait_tick($sformatf("nom_t%0d", i), 40, gap);
            check($sformatf("nom_t%0d_gap", i), 64'(gap), 64'd10);
            check($sformatf("nom_t%0d_dir", i), 64'({bus.tick_rise, bus.tick_fall}),
                  (i % 2 == 1) ? 64'b10 : 64'b01);
            check($sformatf("nom_t%0d_locked", i), 64'(bus.locked), 64'd1);
            check($sformatf("nom_t%0d_hp", i), 64'(bus.half_period), 64'd10);
        end

        // Timeout: stop toggling, lost exactly TIMEOUT cycles after last tick
        tog_period   = 0;
        first_lost   = 0;
        first_unlock = 0;
        for (int j = 1; j <= 40; j++) begin
            cyc();
            if (bus.lost && first_lost == 0)    first_lost = j;
            if (!bus.locked && first_unlock == 0) first_unlock = j;
        end
        check("to_lost_delay", 64'(first_lost), 64'd30);
        check("to_unlock_delay", 64'(first_unlock), 64'd30);
        check("to_status", 64'({bus.locked, bus.lost}), 64'b01);

        // Recovery: first tick clears lost, second relocks
        tog_period = 10;
        tog_cnt    = 0;
        wait_tick("rec_t1", 40, gap);
        check("rec_t1_status", 64'({bus.locked, bus.lost}), 64'b00);
        check("rec_t1_hp_stale", 64'(bus.half_period), 64'd10);
        wait_tick("rec_t2", 40, gap);
        check("rec_t2_gap", 64'(gap), 64'd10);
        check("rec_t2_locked", 64'(bus.locked), 64'd1);
        check("rec_t2_hp", 64'(bus.half_period), 64'd10);

        // Edges exactly TIMEOUT apart never declare loss
        tog_period = 30;
        saw_lost   = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wait_tick($sformatf("bnd_t%0d", i), 45, gap);
            check($sformatf("bnd_t%0d_gap", i), 64'(gap), 64'd30);
            check($sformatf("bnd_t%0d_hp", i), 64'(bus.half_period), 64'd30);
        end
        check("bnd_no_lost", 64'(saw_lost), 64'd0);
        check("bnd_locked", 64'(bus.locked), 64'd1);

        // clk_d held high through reset: no spurious tick, stays in ACQ1
        do_reset(1'b1);
        saw_tick = 1'b0;
        saw_lost = 1'b0;
        repeat (50) cyc();
        check("hi_no_tick", 64'(saw_tick), 64'd0);
        check("hi_no_lost", 64'(saw_lost), 64'd0);
        check("hi_status", 64'({bus.locked, bus.lost, bus.half_period}), 64'd0);

        // Reset mid-operation
        tog_period = 10;
        tog_cnt    = 0;
        wait_tick("mid_t1", 40, gap);
        wait_tick("mid_t2", 40, gap);
        check("mid_pre_locked", 64'(bus.locked), 64'd1);
        check("mid_pre_hp", 64'(bus.half_period), 64'd10);
        repeat (4) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_clear",
              64'({bus.tick_rise, bus.tick_fall, bus.tick_any, bus.locked, bus.lost, bus.half_period}),
              64'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        wait_tick("mid_post_t1", 40, gap);
        check("mid_post_t1_status", 64'({bus.locked, bus.lost, bus.half_period}), 64'd0);
        wait_tick("mid_post_t2", 40, gap);
        check("mid_post_t2_gap", 64'(gap), 64'd10);
        check("mid_post_t2_locked", 64'(bus.locked), 64'd1);
        check("mid_post_t2_hp", 64'(bus.half_period), 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slow_clk_monitor.md
# slow_clk_monitor

Fast-domain consumer of a divided, toggling slow clock such as the game-rate signal `clk_d`. It synchronises the toggle into the `clk` domain and emits single-cycle rise, fall and any-edge tick pulses for game logic. It also measures the half-period in `clk` cycles and reports lock and loss-of-clock status to the scoring and display logic.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `CNT_W`, 26: width of the half-period counter and measurement.
- `TIMEOUT`, 8333332: `clk` cycles without an edge before `lost` is declared. Must be < 2^CNT_W.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_d` in 1: slow toggling input. May be asynchronous to `clk`.
- `tick_rise` out 1: one-cycle pulse per synchronised 0→1 edge of `clk_d`.
- `tick_fall` out 1: one-cycle pulse per synchronised 1→0 edge.
- `tick_any` out 1: `tick_rise | tick_fall`.
- `half_period` out CNT_W: `clk` cycles between the last two detected edges.
- `locked` out 1: a valid measurement exists and no timeout has occurred since.
- `lost` out 1: timeout occurred; held until the next detected edge.

## Operation
- **Synchroniser.** `clk_d` passes through a `SYNC_STAGES`-deep flop chain, reset to 0. A `prev` register holds the chain output from the prior cycle. An edge is `sync_out != prev`.
- **Arming.**
  - `armed` clears on reset and sets after `SYNC_STAGES+1` cycles following reset release.
  - Before `armed` is set, `prev` tracks `sync_out` and no edge is reported.
  - So a `clk_d` held high through reset produces no spurious tick.
- **Counter `cnt` (CNT_W).**
  - Cleared to 0 in the cycle an edge is detected.
  - Otherwise increments each cycle and saturates at `TIMEOUT`.
- **Measurement.** On a detected edge, `half_period <= cnt + 1`, computed CNT_W wide. Because `cnt` saturates, the +1 never wraps.
- **State machine (ACQ1, ACQ2, LOCKED, LOST).** Reset state is ACQ1.
  - ACQ1: first edge → ACQ2. `half_period` is not updated.
  - ACQ2: edge → LOCKED, and `half_period` is updated.
  - ACQ2 or LOCKED: `cnt == TIMEOUT-1` with no edge in that cycle → LOST.
  - LOCKED: each edge updates `half_period` and the state stays LOCKED.
  - LOST: edge → ACQ2 and `lost` clears. That edge restarts the count; `half_period` keeps its stale value until the next edge.
  - ACQ1 never times out.
- **Outputs.**
  - `locked` = (state == LOCKED).
  - `lost` = (state == LOST).
  - All outputs are registered.
- **Simultaneous events.** An edge in the same cycle as `cnt == TIMEOUT-1`: the edge wins, no LOST, and the measurement equals `TIMEOUT`.
- **Reset mid-operation.** Asynchronously forces every register to its reset value within the same cycle. Ticks in flight are dropped.

## Timing
- **Reset values.** `tick_*` = 0, `half_period` = 0, `locked` = 0, `lost` = 0, `cnt` = 0, state ACQ1.
- **Tick latency.**
  - Let edge k be the first `clk` edge that samples the new `clk_d` level.
  - The edge is detected at edge k+SYNC_STAGES.
  - `tick_*` is high for exactly the one cycle following edge k+SYNC_STAGES.
  - With the default `SYNC_STAGES`=2, the tick is visible after edge k+2.
- **Update timing.** `half_period`, `locked` and `lost` update on the same edge that raises the tick.
- **Timeout.** `lost` rises `TIMEOUT` cycles after the last tick cycle.
- **Throughput.**
  - Edges spaced ≥ 2 cycles apart at the chain output are each reported.
  - A level change shorter than one `clk` period may be missed; this is permitted.
- **Steady-state value.** For a source toggling every N+1 `clk` cycles, `half_period` = N+1. With the team divider default, this is 4166666.

## Test plan
- **Nominal lock.** `clk_d` toggles every 10 cycles from reset, `TIMEOUT`=30.
  - `tick_any` occurs every 10 cycles, alternating rise and fall.
  - `locked` = 1 from the second tick.
  - `half_period` = 10.
- **Timeout and recovery.**
  - Stop toggling after lock → `lost` = 1 and `locked` = 0 exactly 30 cycles after the last tick.
  - Resume toggling every 10 cycles → `lost` = 0 on the first tick and `locked` = 1 on the second.
  - `half_period` after the second tick = 10.
- **Reset with `clk_d` high.** Hold `clk_d` = 1 through and after reset release for 50 cycles → no tick; state stays ACQ1 with `locked` = 0 and `lost` = 0.
- **Edge at timeout boundary.** `TIMEOUT`=30, with successive edges exactly 30 cycles apart → `lost` never asserts and `half_period` = 30.
- **Reset mid-operation.** Assert `rst_n` low while LOCKED with `half_period` = 10.
  - All outputs read 0 immediately, before the next `clk` edge.
  - After release, relock with `half_period` = 10 on the second post-release tick.
- **Latency check.** A single `clk_d` rise is applied synchronously → `tick_rise` is high for one cycle, after `clk` edge k+2, with default `SYNC_STAGES`.
